// File: rtl/swan_ks_pkg.sv
// SWAN key schedule: shared state encoding, delta constants, rotations.
// Rotations work on the low w bits of a wide carrier vector.
package swan_ks_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRECOMP,
    FWD_EMIT,
    REV_EMIT,
    DONE
  } ks_state_e;

  localparam logic [31:0] DELTA32 = 32'h9e3779b9;
  localparam logic [63:0] DELTA64 = 64'h9e3779b97f4a7c15;

  localparam int RMAX = 1024;
  typedef logic [RMAX-1:0] rvec_t;

  function automatic rvec_t rotl(
    input rvec_t x,
    input int    w,
    input int    n
  );
    rvec_t m;
    m = '1;
    m = m >> (RMAX - w);
    return ((x << n) | (x >> (w - n))) & m;
  endfunction

  function automatic rvec_t rotr(
    input rvec_t x,
    input int    w,
    input int    n
  );
    return rotl(x, w, w - n);
  endfunction

endpackage

// File: rtl/swan_key_schedule_seq_if.sv
// Subkey stream: valid/ready handshake carrying subkey and round index.
// The schedule engine is the master, the round datapath the slave.
interface swan_key_schedule_seq_if #(
  parameter int SIDE_SIZE = 64,
  parameter int RW        = 6
);
  logic                 sk_valid;
  logic                 sk_ready;
  logic [SIDE_SIZE-1:0] sk;
  logic [RW-1:0]        sk_round;

  modport master (
    output sk_valid,
    output sk,
    output sk_round,
    input  sk_ready
  );

  modport slave (
    input  sk_valid,
    input  sk,
    input  sk_round,
    output sk_ready
  );
endinterface

// File: rtl/swan_ks_step.sv
// One SWAN key-schedule step: forward F (dir=0) or inverse G (dir=1).
// low is the subkey word of the resulting key state.
module swan_ks_step
  import swan_ks_pkg::*;
#(
  parameter int KEY_SIZE  = 256,
  parameter int SIDE_SIZE = 64,
  parameter int PD        = 56,
  parameter logic [SIDE_SIZE-1:0] DELTA =
    (SIDE_SIZE == 32) ? SIDE_SIZE'(DELTA32)
                      : SIDE_SIZE'(DELTA64)
) (
  input  logic [KEY_SIZE-1:0]  k,
  input  logic [SIDE_SIZE-1:0] d,
  input  logic                 dir,
  output logic [KEY_SIZE-1:0]  k_next,
  output logic [SIDE_SIZE-1:0] d_next,
  output logic [SIDE_SIZE-1:0] low
);

  logic [KEY_SIZE-1:0]  kf;
  logic [KEY_SIZE-1:0]  kg;
  logic [SIDE_SIZE-1:0] df;

  always_comb begin
    df = d + DELTA;
    kf = KEY_SIZE'(rotr(RMAX'(k), KEY_SIZE, PD));
    kf[SIDE_SIZE-1:0] = kf[SIDE_SIZE-1:0] + df;
    // G undoes the low-word add before undoing the rotation
    kg = k;
    kg[SIDE_SIZE-1:0] = k[SIDE_SIZE-1:0] - d;
    kg = KEY_SIZE'(rotl(RMAX'(kg), KEY_SIZE, PD));
    k_next = dir ? kg : kf;
    d_next = dir ? (d - DELTA) : df;
  end

  assign low = k_next[SIDE_SIZE-1:0];

endmodule

// File: rtl/swan_key_schedule_seq.sv
// Iterative SWAN key schedule streaming subkeys in either round order.
// Decryption order fast-forwards the state first, then walks back with G.
module swan_key_schedule_seq
  import swan_ks_pkg::*;
#(
  parameter int          BLOCK_SIZE = 128,
  parameter int          KEY_SIZE   = 256,
  parameter int          ROUNDS     = 32,
  parameter int          PD         = 56,
  parameter logic [63:0] DELTA0     = DELTA64,
  parameter int          RW         = $clog2(ROUNDS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic [KEY_SIZE-1:0] key_in,
  output logic                busy,
  output logic                done,
  swan_key_schedule_seq_if.master ks
);

  localparam int SIDE_SIZE = BLOCK_SIZE / 2;
  localparam logic [RW-1:0] LAST     = RW'(ROUNDS);
  localparam logic [RW-1:0] LAST_PRE = RW'(ROUNDS - 1);
  localparam logic [RW-1:0] FIRST    = RW'(1);

  ks_state_e state;
  ks_state_e state_n;

  logic [KEY_SIZE-1:0]  k;
  logic [KEY_SIZE-1:0]  k_in;
  logic [KEY_SIZE-1:0]  k_nx;
  logic [SIDE_SIZE-1:0] d;
  logic [SIDE_SIZE-1:0] d_in;
  logic [SIDE_SIZE-1:0] d_nx;
  logic [SIDE_SIZE-1:0] low;
  logic [RW-1:0]        cnt;
  logic                 hs;
  logic                 dir;

  assign hs  = ks.sk_valid & ks.sk_ready;
  assign dir = (state == REV_EMIT);

  // In IDLE the step sees the fresh key so round 1 is ready next cycle
  assign k_in = (state == IDLE) ? key_in : k;
  assign d_in = (state == IDLE) ? '0 : d;

  swan_ks_step #(
    .KEY_SIZE  (KEY_SIZE),
    .SIDE_SIZE (SIDE_SIZE),
    .PD        (PD),
    .DELTA     (SIDE_SIZE'(DELTA0))
  ) u_step (
    .k      (k_in),
    .d      (d_in),
    .dir    (dir),
    .k_next (k_nx),
    .d_next (d_nx),
    .low    (low)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (start) state_n = mode ? PRECOMP : FWD_EMIT;
      PRECOMP:
        if (cnt == LAST_PRE) state_n = REV_EMIT;
      FWD_EMIT:
        if (hs && ks.sk_round == LAST) state_n = DONE;
      REV_EMIT:
        if (hs && ks.sk_round == FIRST) state_n = DONE;
      DONE:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k           <= '0;
      d           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ks.sk_valid <= 1'b0;
      ks.sk       <= '0;
      ks.sk_round <= '0;
    end else begin
      busy        <= (state_n != IDLE);
      done        <= (state_n == DONE);
      ks.sk_valid <= (state_n inside {FWD_EMIT, REV_EMIT});
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            if (mode) begin
              k <= key_in;
              d <= '0;
            end else begin
              k           <= k_nx;
              d           <= d_nx;
              ks.sk       <= low;
              ks.sk_round <= FIRST;
            end
          end
        end
        PRECOMP: begin
          k   <= k_nx;
          d   <= d_nx;
          cnt <= cnt + 1'b1;
          if (state_n == REV_EMIT) begin
            ks.sk       <= low;
            ks.sk_round <= LAST;
          end
        end
        FWD_EMIT: begin
          if (hs && state_n == FWD_EMIT) begin
            k           <= k_nx;
            d           <= d_nx;
            ks.sk       <= low;
            ks.sk_round <= ks.sk_round + 1'b1;
          end
        end
        REV_EMIT: begin
          if (hs && state_n == REV_EMIT) begin
            k           <= k_nx;
            d           <= d_nx;
            ks.sk       <= low;
            ks.sk_round <= ks.sk_round - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_swan_key_schedule_seq.sv
// Bench for swan_key_schedule_seq: four parameter sets driven in parallel,
// checked each cycle against a bit-level schedule model and timeline.
module tb_swan_key_schedule_seq;

  localparam int NI = 4;
  localparam int BS_A [NI] = '{128, 64, 128, 64};
  localparam int KS_A [NI] = '{256, 128, 128, 128};
  localparam int R_A  [NI] = '{32, 12, 7, 1};
  localparam int PD_A [NI] = '{56, 37, 64, 5};
  localparam logic [63:0] DL_A [NI] = '{
    64'h9e3779b97f4a7c15, 64'h0000_0000_9e3779b9,
    64'h9e3779b97f4a7c15, 64'h0000_0000_9e3779b9};

  typedef struct {
    int          r;
    logic [63:0] sk;
  } item_t;

  logic clk;
  logic rst_n;
  logic [NI-1:0] start_v, mode_v, rdy_v;
  logic [NI-1:0] busy_v, done_v, vld_v;
  logic [NI-1:0][255:0] key_v;
  logic [NI-1:0][63:0]  sk_v;
  logic [NI-1:0][7:0]   rnd_v;

  int n_pass = 0;
  int n_total = 0;

  item_t q [NI][$];
  bit    act [NI];
  bit    dn  [NI];
  int    wt  [NI];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int BS = BS_A[g];
    localparam int KS = KS_A[g];
    localparam int R  = R_A[g];
    localparam int P  = PD_A[g];
    localparam logic [63:0] DL = DL_A[g];
    localparam int RWG = $clog2(R + 1);

    swan_key_schedule_seq_if #(
      .SIDE_SIZE (BS / 2),
      .RW        (RWG)
    ) bus ();

    swan_key_schedule_seq #(
      .BLOCK_SIZE (BS),
      .KEY_SIZE   (KS),
      .ROUNDS     (R),
      .PD         (P),
      .DELTA0     (DL),
      .RW         (RWG)
    ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start_v[g]),
      .mode   (mode_v[g]),
      .key_in (key_v[g][KS-1:0]),
      .busy   (busy_v[g]),
      .done   (done_v[g]),
      .ks     (bus)
    );

    assign bus.sk_ready = rdy_v[g];
    assign vld_v[g]     = bus.sk_valid;
    assign sk_v[g]      = 64'(bus.sk);
    assign rnd_v[g]     = 8'(bus.sk_round);
  end

  function automatic void chk(input string nm, input int g,
                              input logic [63:0] got,
                              input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s inst%0d got %h want %h", nm, g, got, exp);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[i*32 +: 32] = $urandom;
    return k;
  endfunction

  // Applies F r times straight from the definition, bit by bit
  function automatic void model(input int g, input logic [255:0] key,
                                output logic [63:0] seq[$]);
    logic [255:0] k, t;
    logic [63:0] d, m;
    int kw, sw;
    kw = KS_A[g];
    sw = BS_A[g] / 2;
    m = (sw >= 64) ? 64'hffff_ffff_ffff_ffff
                   : ((64'd1 << sw) - 64'd1);
    k = '0;
    for (int i = 0; i < kw; i++) k[i] = key[i];
    d = '0;
    seq.delete();
    for (int r = 0; r < R_A[g]; r++) begin
      d = (d + DL_A[g]) & m;
      t = '0;
      for (int i = 0; i < kw; i++) t[i] = k[(i + PD_A[g]) % kw];
      k = t;
      k[63:0] = (k[63:0] & ~m) | ((k[63:0] + d) & m);
      seq.push_back(k[63:0] & m);
    end
  endfunction

  function automatic void load(input int g, input logic [255:0] key,
                               input bit dec);
    logic [63:0] s[$];
    int j;
    model(g, key, s);
    q[g].delete();
    for (int i = 0; i < R_A[g]; i++) begin
      j = dec ? (R_A[g] - 1 - i) : i;
      q[g].push_back('{r: j + 1, sk: s[j]});
    end
    act[g] = 1'b1;
    dn[g]  = 1'b0;
    wt[g]  = dec ? R_A[g] : 0;
  endfunction

  function automatic void compare();
    logic ev;
    for (int g = 0; g < NI; g++) begin
      ev = act[g] && wt[g] == 0 && q[g].size() > 0;
      chk("sk_valid", g, 64'(vld_v[g]), 64'(ev));
      chk("done", g, 64'(done_v[g]), 64'(dn[g]));
      chk("busy", g, 64'(busy_v[g]), 64'(act[g]));
      if (ev && vld_v[g]) begin
        chk("sk", g, sk_v[g], q[g][0].sk);
        chk("sk_round", g, 64'(rnd_v[g]), 64'(q[g][0].r));
      end
    end
  endfunction

  // Moves the expected timeline one cycle, given this cycle's inputs
  function automatic void advance();
    for (int g = 0; g < NI; g++) begin
      if (!rst_n) begin
        act[g] = 1'b0;
        dn[g]  = 1'b0;
        wt[g]  = 0;
        q[g].delete();
      end else if (dn[g]) begin
        dn[g]  = 1'b0;
        act[g] = 1'b0;
      end else if (act[g]) begin
        if (wt[g] > 0) wt[g]--;
        else if (rdy_v[g]) begin
          q[g].delete(0);
          if (q[g].size() == 0) dn[g] = 1'b1;
        end
      end else if (start_v[g]) begin
        load(g, key_v[g], mode_v[g]);
      end
    end
  endfunction

  function automatic void check_zero(input string nm);
    for (int g = 0; g < NI; g++) begin
      chk({nm, "_valid"}, g, 64'(vld_v[g]), 64'd0);
      chk({nm, "_busy"}, g, 64'(busy_v[g]), 64'd0);
      chk({nm, "_done"}, g, 64'(done_v[g]), 64'd0);
      chk({nm, "_sk"}, g, sk_v[g], 64'd0);
      chk({nm, "_round"}, g, 64'(rnd_v[g]), 64'd0);
    end
  endfunction

  function automatic bit any_act();
    bit a;
    a = 1'b0;
    for (int g = 0; g < NI; g++) a |= act[g];
    return a;
  endfunction

  task automatic sample();
    @(negedge clk);
    compare();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (any_act() && n < 300) begin
      sample();
      start_v = '0;
      rdy_v   = '1;
      advance();
      n++;
    end
    sample();
    chk("drain_idle", 0, 64'(busy_v), 64'd0);
    start_v = '0;
    advance();
  endtask

  // Key-0 encryption on inst0 with start held high throughout:
  // pulses while busy (incl. done) must be ignored, next idle cycle restarts
  task automatic run_golden();
    for (int c = 0; c < 90; c++) begin
      sample();
      start_v    = '0;
      start_v[0] = 1'b1;
      mode_v[0]  = 1'b0;
      key_v[0]   = act[0] ? rand256() : '0;
      rdy_v      = '1;
      advance();
    end
    drain();
  endtask

  task automatic run_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      sample();
      for (int g = 0; g < NI; g++) begin
        start_v[g] = ($urandom_range(0, 4) == 0);
        mode_v[g]  = 1'($urandom_range(0, 1));
        key_v[g]   = rand256();
        rdy_v[g]   = 1'($urandom_range(0, 1));
      end
      advance();
    end
    drain();
  endtask

  initial begin
    logic [63:0] s[$];
    rst_n   = 1'b0;
    start_v = '0;
    mode_v  = '0;
    rdy_v   = '0;
    key_v   = '0;

    model(0, '0, s);
    chk("pin64_r1", 0, s[0], 64'h9e3779b97f4a7c15);
    chk("pin64_r2", 0, s[1], 64'h3c6ef372fe94f8c8);
    model(1, '0, s);
    chk("pin32_r1", 1, s[0], 64'h9e3779b9);
    chk("pin32_r2", 1, s[1], 64'h3c6ef372);

    sample();
    check_zero("reset");
    advance();
    sample();
    rst_n = 1'b1;
    advance();

    run_golden();
    run_random(1500);

    // Abort inst0 mid-PRECOMP and inst1 mid-FWD_EMIT
    sample();
    start_v    = '0;
    start_v[0] = 1'b1;
    mode_v[0]  = 1'b1;
    key_v[0]   = rand256();
    start_v[1] = 1'b1;
    mode_v[1]  = 1'b0;
    key_v[1]   = rand256();
    rdy_v      = '1;
    advance();
    repeat (10) begin
      sample();
      start_v = '0;
      advance();
    end
    sample();
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    start_v = '0;
    advance();
    sample();
    advance();
    sample();
    rst_n = 1'b1;
    advance();

    run_golden();
    run_random(300);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/swan_key_schedule_seq.md
# swan_key_schedule_seq

Iterative, parametrised SWAN key-schedule engine. It accepts a master key and streams round subkeys, one per cycle under valid/ready backpressure, in encryption order (round 1..ROUNDS) or decryption order (ROUNDS..1). In decryption mode it first fast-forwards the key state internally, so no external precomputed final key/delta is needed. It replaces per-size combinational decryption schedule instances beside the SWAN round datapath and covers all block/key sizes with one block.

## Interface
- BLOCK_SIZE, 128: cipher block width; SIDE_SIZE = BLOCK_SIZE/2 is the subkey width.
- KEY_SIZE, 256: key register width; must be a multiple of SIDE_SIZE.
- ROUNDS, 32: subkeys per schedule, ≥ 1.
- PD, 56: key rotation distance, 0 < PD < KEY_SIZE.
- DELTA0, 64'h9e3779b97f4a7c15: delta increment; the low SIDE_SIZE bits are used.
- RW, $clog2(ROUNDS+1): round index width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a schedule; sampled only in IDLE.
- mode  in  1  0 = encryption order, 1 = decryption order; sampled with start.
- key_in  in  KEY_SIZE  master key, MSB-first; sampled with start.
- busy  out  1  high in every state except IDLE.
- sk_valid  out  1  sk and sk_round are valid.
- sk_ready  in  1  consumer accepts; handshake = sk_valid & sk_ready.
- sk  out  SIDE_SIZE  round subkey.
- sk_round  out  RW  round number of sk, 1..ROUNDS.
- done  out  1  one-cycle pulse after the final handshake.

## Operation
- State is (k, d): k is KEY_SIZE bits, d is SIDE_SIZE bits. low(k) = the least-significant SIDE_SIZE bits of k. All arithmetic is mod 2^SIDE_SIZE.
- Forward step F: d' = d + DELTA0; k' = rotr(k, PD) with low(k') += d'.
- Inverse step G: low(k) -= d; k' = rotl(k, PD); d' = d − DELTA0.
- Rotations are numeric: rotl moves bits toward the MSB.
- G is the exact inverse of F.
- Starting state is (key_in, 0). Applying F r times gives (k_r, d_r). The subkey for round r is sk_r = low(k_r).
- FSM states:
  - IDLE: start=1 loads (key_in, 0) and latches mode. Go to FWD_EMIT if mode=0, PRECOMP if mode=1.
  - PRECOMP: apply F each cycle for ROUNDS cycles, ending at (k_R, d_R). Then go to REV_EMIT. No output.
  - FWD_EMIT: the output register holds F(current state). On each handshake, advance and increment sk_round, which starts at 1.
  - REV_EMIT: present sk = low(k) with sk_round = ROUNDS, counting down. On each handshake apply G.
  - Both emit states go to DONE after the handshake of the ROUNDS-th subkey.
  - DONE: done=1 for one cycle, then IDLE.
- The round counter must never wrap. Exactly ROUNDS handshakes occur per schedule.
- start while busy=1 is ignored; it is not queued.

## Timing
- Reset values: busy=0, sk_valid=0, sk=0, sk_round=0, done=0. FSM goes to IDLE and k, d, mode and counters clear.
- Reset asserted mid-schedule aborts it immediately. No done pulse is produced.
- Encryption: start in cycle t gives sk_valid=1 with round 1 in cycle t+1.
- Decryption: start in cycle t gives the first sk_valid in cycle t+1+ROUNDS.
- Throughput is one subkey per cycle while sk_ready=1.
- While sk_valid=1 and sk_ready=0, sk and sk_round hold stable and state does not advance.
- sk_valid never drops without a handshake.
- done is high in the cycle after the final handshake, with sk_valid=0. busy falls in the following cycle, and start is accepted then.
- All outputs are registered. No combinational path from sk_ready to sk_valid.

## Structure
- Package swan_ks_pkg holds:
  - the state enum {IDLE, PRECOMP, FWD_EMIT, REV_EMIT, DONE};
  - default DELTA constants for 32- and 64-bit sides;
  - rotl/rotr functions parametrised on width and distance.
- Sub-module swan_ks_step is a combinational F/G selector: inputs k, d, dir; outputs k', d', low. It is instantiated once and shared by PRECOMP and both emit states.

## Test plan
- Encryption, key_in=0, default parameters, sk_ready=1:
  - sk round 1 = 0x9e3779b97f4a7c15;
  - sk round 2 = 0x3c6ef372fe94f8c8;
  - ROUNDS subkeys, then one done pulse.
- Decryption with a random key gives exactly the reversed encryption sequence. The first sk_valid arrives ROUNDS+1 cycles after start, with sk_round counting ROUNDS..1.
- Random sk_ready backpressure (about 50%): sk and sk_round stay stable while stalled, and no subkey is lost or duplicated.
- start pulsed during busy, and simultaneously with done: the pulse is ignored and the sequence is unchanged. start in the cycle after busy falls begins a new schedule.
- rst_n pulsed low mid-PRECOMP and mid-FWD_EMIT: outputs are 0 immediately and there is no done pulse. A restarted schedule matches the golden sequence.
- Parameter sweep: BLOCK_SIZE=64/KEY_SIZE=128/DELTA0=32'h9e3779b9 and BLOCK_SIZE=128/KEY_SIZE=128 match the reference model for encryption and decryption, including ROUNDS=1.
